inst_prefetch_buffer: RTL and testbench
=======================================

INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, instruction address width.
REQ-002 SHALL have parameter INST_WIDTH, 32, instruction word width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, 4, buffer entries (power of 2, >=4).
REQ-004 SHALL have parameter RESET_PC, 0, first fetch address after reset.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port fetch_en  in  1  permit new ROM fetches.
REQ-008 SHALL have port redirect_en  in  1  flush buffer, restart at redirect_addr.
REQ-009 SHALL have port redirect_addr  in  ADDR_WIDTH  new fetch address.
REQ-010 SHALL have port rom_en  out  1  ROM read strobe.
REQ-011 SHALL have port rom_addr  out  ADDR_WIDTH  ROM read address.
REQ-012 SHALL have port rom_inst  in  INST_WIDTH  ROM data, valid the cycle after rom_en.
REQ-013 SHALL have port inst_valid  out  1  head entry available.
REQ-014 SHALL have port inst_ready  in  1  consumer accepts head.
REQ-015 SHALL have port inst_o  out  INST_WIDTH  head instruction.
REQ-016 SHALL have port addr_o  out  ADDR_WIDTH  address of head instruction.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, STALL: IDLE->RUN when fetch_en=1, RUN->STALL when fetch_en=0, STALL->RUN when fetch_en=1; IDLE issues no fetch.
REQ-018 SHALL assert rom_en in cycle t only when state RUN, fetch_en=1, redirect_en=0 and count+inflight<DEPTH (registered values; same-cycle pop not credited).
REQ-019 SHALL drive rom_addr from the PC register; on each fetch, PC advances by INST_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL write rom_inst and its address into the buffer at the end of cycle t+1 for a fetch issued in cycle t (issue-to-inst_valid latency 2 cycles).
REQ-021 SHALL drive inst_valid = (count!=0) and redirect_en=0; inst_o/addr_o = head entry when inst_valid=1, else 0.
REQ-022 SHALL pop the head when inst_valid and inst_ready are both 1; simultaneous push and pop leaves count unchanged.
REQ-023 SHALL, on redirect_en=1 in cycle c: clear buffer, discard the response arriving in cycle c, load PC with redirect_addr (low log2(INST_WIDTH/8) bits forced 0), issue no fetch in c; first fetch of redirect_addr in c+1 if RUN.
REQ-024 SHALL accept redirect in any state; in STALL/IDLE the PC updates and fetching waits for RUN.
REQ-025 SHALL never overflow: credit rule REQ-018 guarantees count<=DEPTH; pop on empty is ignored.
REQ-026 SHALL sustain one instruction per cycle when fetch_en=1 and inst_ready=1 continuously.
REQ-027 SHALL size count as log2(DEPTH)+1 bits and pointers as log2(DEPTH) bits with natural wrap.

Reset
REQ-028 SHALL, while rst=0, force state IDLE, PC=RESET_PC, count=0, inflight=0, rom_en=0, rom_addr=RESET_PC, inst_valid=0, inst_o=0, addr_o=0.
REQ-029 SHALL, on reset asserted mid-operation, drop all buffered and in-flight instructions; no stale entry appears after release.

Structure
REQ-030 SHALL place parameter defaults and FSM state encoding in the shared global define package.
REQ-031 SHALL instantiate one sub-module inst_fifo (synchronous DEPTH-entry FIFO with flush) for storage; FSM, PC and credit logic in the top.

Verification
REQ-032 SHALL test reset release, fetch_en=1, inst_ready=1, ROM word=addr -> rom_addr 0,4,8,...; inst_valid from 3rd cycle after release, then every cycle, addr_o 0,4,8.
REQ-033 SHALL test inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered, rom_en low after, no entry lost or duplicated on resume.
REQ-034 SHALL test redirect to 0x103 while 3 entries buffered and 1 in flight -> inst_valid low 3 cycles, next addr_o=0x100, no old address seen.
REQ-035 SHALL test PC=0xFFFFFFFC, fetch 2 words -> rom_addr 0xFFFFFFFC then 0x00000000.
REQ-036 SHALL test fetch_en toggled 0/1 every 2 cycles with random inst_ready -> output order matches ascending addresses, count never exceeds 4.
REQ-037 SHALL test rst asserted with 2 entries buffered -> all outputs reset values immediately; after release first addr_o=RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: parameter defaults
// and the fetch-control state encoding.
package inst_prefetch_buffer_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_INST_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam logic [63:0] DEF_RESET_PC   = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// DEPTH-entry first-word-fall-through FIFO with synchronous flush; holds
// fetched {address, instruction} pairs for the prefetch buffer.
module inst_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Push into a full FIFO and pop from an empty one are both dropped.
    assign do_push = push && (count_reg != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale words are never visible because the
    // consumer side gates everything on count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: fetch FSM, PC and credit logic in front of a
// small FIFO of {address, instruction} pairs read from a 1-cycle-latency ROM.
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned            INST_WIDTH = DEF_INST_WIDTH,
    parameter int unsigned            DEPTH      = DEF_DEPTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect_en,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INST_WIDTH-1:0]  rom_inst,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_WIDTH-1:0]  inst_o,
    output logic [ADDR_WIDTH-1:0]  addr_o
);

    localparam int unsigned            BYTES      = INST_WIDTH / 8;
    localparam int unsigned            CNT_W      = $clog2(DEPTH) + 1;
    localparam int unsigned            ENTRY_W    = ADDR_WIDTH + INST_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  PC_STEP    = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

    fetch_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic                   inflight_reg;
    logic [ADDR_WIDTH-1:0]  inflight_addr_reg;
    logic [CNT_W-1:0]       fifo_count;
    logic [ENTRY_W-1:0]     head_data;
    logic                   credit_ok;
    logic                   push;
    logic                   pop;

    // Credit counts the in-flight word so a response always has a free slot;
    // a pop in the same cycle is deliberately not credited.
    assign credit_ok = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg)) < (CNT_W + 1)'(DEPTH);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fetch_en)  state_next = ST_RUN;
            ST_RUN:   if (!fetch_en) state_next = ST_STALL;
            ST_STALL: if (fetch_en)  state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase

        rom_en = (state_reg == ST_RUN) && fetch_en && !redirect_en && credit_ok;

        pc_next = pc_reg;
        if (redirect_en)  pc_next = redirect_addr & ALIGN_MASK;
        else if (rom_en)  pc_next = pc_reg + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= ST_IDLE;
            pc_reg            <= RESET_PC;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= rom_en;
            if (rom_en) inflight_addr_reg <= pc_reg;
        end
    end

    assign rom_addr = pc_reg;

    // A response landing in a redirect cycle belongs to the old stream.
    assign push       = inflight_reg && !redirect_en;
    assign inst_valid = (fifo_count != '0) && !redirect_en;
    assign pop        = inst_valid && inst_ready;

    inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_en),
        .push      (push),
        .push_data ({inflight_addr_reg, rom_inst}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign inst_o = inst_valid ? head_data[INST_WIDTH-1:0] : '0;
    assign addr_o = inst_valid ? head_data[ENTRY_W-1:INST_WIDTH] : '0;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: directed phases plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_inst_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [31:0] addr_o;

    logic [31:0] salt = 32'h0;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state
    int          m_state;          // 0 idle, 1 run, 2 stall
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_inflight;
    logic [31:0] m_inflight_addr;
    bit          e_rom_en;
    bit          e_valid;

    inst_prefetch_buffer #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_o        (inst_o),
        .addr_o        (addr_o)
    );

    always #5 clk = ~clk;

    // ROM: word returned one cycle after the address is presented
    always @(posedge clk) rom_inst <= rom_addr ^ salt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_pc       = 32'h0;
        m_q.delete();
        m_inflight = 0;
        m_inflight_addr = 32'h0;
    endtask

    task automatic model_update();
        if (redirect_en) begin
            m_q.delete();
            m_inflight = 0;
            m_pc = {redirect_addr[31:2], 2'b00};
        end else begin
            if (e_valid && inst_ready) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_inflight_addr);
            m_inflight      = e_rom_en;
            m_inflight_addr = m_pc;
            if (e_rom_en) m_pc = m_pc + 32'd4;
        end
        if (m_state == 0 && fetch_en)       m_state = 1;
        else if (m_state == 1 && !fetch_en) m_state = 2;
        else if (m_state == 2 && fetch_en)  m_state = 1;
    endtask

    // One clock: check outputs at the falling edge, advance model at the rising edge.
    task automatic step();
        logic [31:0] e_addr;
        @(negedge clk);
        if (!rst) model_reset();
        e_rom_en = (m_state == 1) && fetch_en && !redirect_en && ((m_q.size() + int'(m_inflight)) < DEPTH);
        e_valid  = (m_q.size() != 0) && !redirect_en;
        e_addr   = e_valid ? m_q[0] : 32'h0;
        check_eq("rom_en",     {63'h0, rom_en},     {63'h0, e_rom_en});
        check_eq("rom_addr",   {32'h0, rom_addr},   {32'h0, m_pc});
        check_eq("inst_valid", {63'h0, inst_valid}, {63'h0, e_valid});
        check_eq("addr_o",     {32'h0, addr_o},     {32'h0, e_addr});
        check_eq("inst_o",     {32'h0, inst_o},     {32'h0, (e_valid ? (e_addr ^ salt) : 32'h0)});
        check_eq("count",      {61'h0, dut.u_fifo.count_reg}, 64'(m_q.size()));
        if (inst_valid && inst_ready)
            $display("cycle=%0d pop addr=%08h inst=%08h", cycle, addr_o, inst_o);
        @(posedge clk);
        if (!rst) model_reset();
        else      model_update();
        cycle++;
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b0; fetch_en = 1'b0; redirect_en = 1'b0;
        redirect_addr = 32'h0; inst_ready = 1'b0;
        model_reset();
        repeat (3) step();

        // Streaming from reset: ascending addresses, one per cycle
        rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
        repeat (20) step();

        // Consumer stall: buffer fills to DEPTH, fetch stops, resume is lossless
        inst_ready = 1'b0;
        repeat (10) step();
        inst_ready = 1'b1;
        repeat (10) step();

        // Redirect with 3 buffered and 1 in flight
        inst_ready = 1'b0;
        n = 0;
        while (!(m_q.size() == 3 && m_inflight) && n < 30) begin step(); n++; end
        if (n == 30) check_eq("wait_3buf", 64'h0, 64'h1);
        redirect_en = 1'b1; redirect_addr = 32'h0000_0103; inst_ready = 1'b1;
        step();
        redirect_en = 1'b0;
        repeat (10) step();

        // Address wrap at the top of the space
        redirect_en = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        step();
        redirect_en = 1'b0;
        repeat (8) step();

        // fetch_en toggling every 2 cycles, random consumer, sporadic redirects
        for (int i = 0; i < 200; i++) begin
            fetch_en    = ((i / 2) % 2) == 0;
            inst_ready  = $urandom_range(0, 1) == 1;
            redirect_en = $urandom_range(0, 31) == 0;
            redirect_addr = $urandom();
            step();
        end
        redirect_en = 1'b0;

        // Drain, then reset with 2 entries buffered
        fetch_en = 1'b0; inst_ready = 1'b1;
        repeat (8) step();
        fetch_en = 1'b1; inst_ready = 1'b0;
        n = 0;
        while (m_q.size() != 2 && n < 30) begin step(); n++; end
        if (n == 30) check_eq("wait_2buf", 64'h0, 64'h1);
        rst  = 1'b0;
        salt = 32'hA5C3_0F96;
        step();
        step();
        rst = 1'b1; inst_ready = 1'b1;
        repeat (15) step();

        // Random tail with the new ROM contents
        for (int i = 0; i < 150; i++) begin
            fetch_en    = $urandom_range(0, 3) != 0;
            inst_ready  = $urandom_range(0, 2) != 0;
            redirect_en = $urandom_range(0, 24) == 0;
            redirect_addr = $urandom();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
